// File: rtl/montador_instrucao_pkg.sv
// Shared RV32I definitions: instruction format codes, opcodes, the NOP word
// and the field bundle latched by the instruction assembler.
package montador_instrucao_pkg;

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] OP     = 7'b0110011;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CODIFICA = 2'd1,
        SAIDA    = 2'd2
    } estado_t;

    typedef struct packed {
        logic [2:0]  formato;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } campos_t;

endpackage

// File: rtl/montador_instrucao_codificador_imediato.sv
// Combinational RV32I encoder: packs the latched fields into a word and
// reports whether the immediate fits the chosen format.
module codificador_imediato
    import montador_instrucao_pkg::*;
(
    input  campos_t     campos_i,
    output logic [31:0] palavra_o,
    output logic        legal_o
);

    logic signed [31:0] imm_s;
    logic [31:0]        im;

    assign im    = campos_i.imm;
    assign imm_s = $signed(campos_i.imm);

    always_comb begin
        palavra_o = '0;
        legal_o   = 1'b0;
        case (campos_i.formato)
            FMT_R: begin
                palavra_o = {campos_i.funct7, campos_i.rs2, campos_i.rs1,
                             campos_i.funct3, campos_i.rd, campos_i.opcode};
                legal_o   = 1'b1;
            end
            FMT_I: begin
                palavra_o = {im[11:0], campos_i.rs1, campos_i.funct3,
                             campos_i.rd, campos_i.opcode};
                legal_o   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            FMT_S: begin
                palavra_o = {im[11:5], campos_i.rs2, campos_i.rs1,
                             campos_i.funct3, im[4:0], campos_i.opcode};
                legal_o   = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            FMT_B: begin
                palavra_o = {im[12], im[10:5], campos_i.rs2, campos_i.rs1,
                             campos_i.funct3, im[4:1], im[11], campos_i.opcode};
                legal_o   = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !im[0];
            end
            FMT_U: begin
                palavra_o = {im[31:12], campos_i.rd, campos_i.opcode};
                legal_o   = (im[11:0] == 12'd0);
            end
            FMT_J: begin
                palavra_o = {im[20], im[10:1], im[11], im[19:12],
                             campos_i.rd, campos_i.opcode};
                legal_o   = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !im[0];
            end
            default: begin
                palavra_o = '0;
                legal_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/montador_instrucao.sv
// Instruction assembler: accepts RV32I fields, emits the encoded word with its
// byte address, substituting a NOP and flagging illegal requests.
//
//   state    | meaning
//   OCIOSO   | idle, in_ready=1, latches a request when in_valid
//   CODIFICA | encodes the latched fields and registers word/error
//   SAIDA    | out_valid=1, holds word/address until out_ready
module montador_instrucao
    import montador_instrucao_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        formato,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] address,
    output logic              erro,
    output logic [7:0]        n_erros
);

    estado_t           estado_q, estado_d;
    campos_t           campos_q, campos_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              erro_q, erro_d;
    logic [7:0]        nerr_q, nerr_d;

    logic [31:0] palavra;
    logic        legal;

    codificador_imediato u_codificador (
        .campos_i  (campos_q),
        .palavra_o (palavra),
        .legal_o   (legal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            campos_q <= '0;
            instr_q  <= '0;
            addr_q   <= BASE_ADDR;
            erro_q   <= 1'b0;
            nerr_q   <= '0;
        end else begin
            estado_q <= estado_d;
            campos_q <= campos_d;
            instr_q  <= instr_d;
            addr_q   <= addr_d;
            erro_q   <= erro_d;
            nerr_q   <= nerr_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        campos_d = campos_q;
        instr_d  = instr_q;
        addr_d   = addr_q;
        erro_d   = erro_q;
        nerr_d   = nerr_q;
        case (estado_q)
            OCIOSO: begin
                if (in_valid) begin
                    campos_d.formato = formato;
                    campos_d.opcode  = opcode;
                    campos_d.rd      = rd;
                    campos_d.rs1     = rs1;
                    campos_d.rs2     = rs2;
                    campos_d.funct3  = funct3;
                    campos_d.funct7  = funct7;
                    campos_d.imm     = imm;
                    estado_d         = CODIFICA;
                end
            end
            CODIFICA: begin
                instr_d  = legal ? palavra : NOP;
                erro_d   = !legal;
                if (!legal && (nerr_q != 8'hFF)) begin
                    nerr_d = nerr_q + 8'd1;
                end
                estado_d = SAIDA;
            end
            SAIDA: begin
                // Illegal words still consume an address so the program layout holds.
                if (out_ready) begin
                    addr_d   = addr_q + ADDR_W'(4);
                    erro_d   = 1'b0;
                    estado_d = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    assign in_ready    = (estado_q == OCIOSO);
    assign out_valid   = (estado_q == SAIDA);
    assign instruction = instr_q;
    assign address     = addr_q;
    assign erro        = erro_q;
    assign n_erros     = nerr_q;

endmodule

// File: tb/tb_montador_instrucao.sv
// Scoreboard bench for montador_instrucao: expected words are queued at input
// acceptance and compared when the output handshake is observed.
module tb_montador_instrucao;
    import montador_instrucao_pkg::*;

    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  formato;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] address;
    logic        erro;
    logic [7:0]  n_erros;

    always #5 clk = ~clk;

    montador_instrucao #(.ADDR_W(32), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .formato(formato), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .out_valid(out_valid),
        .out_ready(out_ready), .instruction(instruction), .address(address),
        .erro(erro), .n_erros(n_erros)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        erro;
        logic [7:0]  nerr;
    } esperado_t;

    esperado_t   sb[$];
    esperado_t   mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_addr;
    logic [7:0]  exp_nerr;
    time         accept_time;

    function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [6:0] op,
                                             input logic [4:0] d, input logic [4:0] s1,
                                             input logic [4:0] s2, input logic [2:0] f3,
                                             input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] w;
        logic [31:0] regs;
        w    = {25'd0, op};
        regs = ({27'd0, s2} << 20) | ({27'd0, s1} << 15) | ({29'd0, f3} << 12);
        case (f)
            3'd0: w = w | ({25'd0, f7} << 25) | regs | ({27'd0, d} << 7);
            3'd1: w = w | ((im & 32'hFFF) << 20) | ({27'd0, s1} << 15) | ({29'd0, f3} << 12) | ({27'd0, d} << 7);
            3'd2: w = w | (((im >> 5) & 32'h7F) << 25) | regs | ((im & 32'h1F) << 7);
            3'd3: w = w | (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | regs
                        | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
            3'd4: w = w | (im & 32'hFFFFF000) | ({27'd0, d} << 7);
            3'd5: w = w | (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                        | (((im >> 11) & 32'h1) << 20) | (im & 32'h000FF000) | ({27'd0, d} << 7);
            default: w = 32'h13;
        endcase
        return w;
    endfunction

    // Output monitor: the handshake completes on the posedge following this negedge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got word %h at %h, required no output", instruction, address);
            end else begin
                mon_e = sb.pop_front();
                if (instruction !== mon_e.instr) begin
                    errors++;
                    $display("FAIL instruction: got %h, required %h", instruction, mon_e.instr);
                end
                checks++;
                if (address !== mon_e.addr) begin
                    errors++;
                    $display("FAIL address: got %h, required %h", address, mon_e.addr);
                end
                checks++;
                if (erro !== mon_e.erro) begin
                    errors++;
                    $display("FAIL erro: got %b, required %b (word %h)", erro, mon_e.erro, mon_e.instr);
                end
                checks++;
                if (n_erros !== mon_e.nerr) begin
                    errors++;
                    $display("FAIL n_erros: got %0d, required %0d", n_erros, mon_e.nerr);
                end
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im,
                        input logic [31:0] exp_word, input logic exp_legal);
        int n;
        formato = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", in_ready, n);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        accept_time = $time;
        in_valid = 1'b0;
        if (!exp_legal && exp_nerr != 8'hFF) exp_nerr++;
        sb.push_back('{exp_legal ? exp_word : 32'h13, exp_addr, !exp_legal, exp_nerr});
        exp_addr += 32'd4;
    endtask

    task automatic wait_idle(input string nome);
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (sb.size() != 0 || !in_ready) begin
            errors++;
            $display("FAIL %s_drain: %0d words pending, in_ready=%b, required 0 pending and 1", nome, sb.size(), in_ready);
        end
    endtask

    task automatic reset_check(input string nome);
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || address !== BASE || n_erros !== 8'd0
            || instruction !== 32'd0 || erro !== 1'b0) begin
            errors++;
            $display("FAIL %s: got out_valid=%b in_ready=%b address=%h n_erros=%0d instruction=%h erro=%b, required 0 1 %h 0 0 0",
                     nome, out_valid, in_ready, address, n_erros, instruction, erro, BASE);
        end
        sb.delete();
        exp_addr = BASE;
        exp_nerr = 8'd0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset_check("reset_state");
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_addi_latency();
        out_ready = 1'b1;
        send(FMT_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00510093, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency_codifica: got out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_saida: got out_valid=%b, required 1", out_valid);
        end
        wait_idle("addi");
    endtask

    task automatic test_store_branch();
        reset_check("reset_before_store");
        out_ready = 1'b1;
        send(FMT_S, STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd0,  32'h0020A023, 1'b1);
        send(FMT_B, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd16, 32'h00208863, 1'b1);
        send(FMT_J, JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFFDFF0EF, 1'b1);
        send(FMT_U, LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b1);
        wait_idle("store_branch");
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        send(FMT_B, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,    32'd0, 1'b0);
        send(FMT_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048, 32'd0, 1'b0);
        send(3'd7,  OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0,    32'd0, 1'b0);
        wait_idle("illegal");
    endtask

    task automatic test_boundaries();
        logic [31:0] v;
        out_ready = 1'b1;
        v = -32'sd2048;   send(FMT_I, OP_IMM, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, v, ref_word(FMT_I, OP_IMM, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, v), 1'b1);
        v = 32'd2047;     send(FMT_I, OP_IMM, 5'd3, 5'd4, 5'd0, 3'd7, 7'd0, v, ref_word(FMT_I, OP_IMM, 5'd3, 5'd4, 5'd0, 3'd7, 7'd0, v), 1'b1);
        v = -32'sd2049;   send(FMT_I, OP_IMM, 5'd3, 5'd4, 5'd0, 3'd0, 7'd0, v, 32'd0, 1'b0);
        v = -32'sd2048;   send(FMT_S, STORE,  5'd0, 5'd6, 5'd7, 3'd2, 7'd0, v, ref_word(FMT_S, STORE, 5'd0, 5'd6, 5'd7, 3'd2, 7'd0, v), 1'b1);
        v = 32'd2048;     send(FMT_S, STORE,  5'd0, 5'd6, 5'd7, 3'd2, 7'd0, v, 32'd0, 1'b0);
        v = -32'sd4096;   send(FMT_B, BRANCH, 5'd0, 5'd8, 5'd9, 3'd1, 7'd0, v, ref_word(FMT_B, BRANCH, 5'd0, 5'd8, 5'd9, 3'd1, 7'd0, v), 1'b1);
        v = 32'd4094;     send(FMT_B, BRANCH, 5'd0, 5'd8, 5'd9, 3'd1, 7'd0, v, ref_word(FMT_B, BRANCH, 5'd0, 5'd8, 5'd9, 3'd1, 7'd0, v), 1'b1);
        v = 32'd4096;     send(FMT_B, BRANCH, 5'd0, 5'd8, 5'd9, 3'd1, 7'd0, v, 32'd0, 1'b0);
        v = 32'd1048574;  send(FMT_J, JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, v, ref_word(FMT_J, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, v), 1'b1);
        v = -32'sd1048576; send(FMT_J, JAL,   5'd2, 5'd0, 5'd0, 3'd0, 7'd0, v, ref_word(FMT_J, JAL, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, v), 1'b1);
        v = 32'd1048576;  send(FMT_J, JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, v, 32'd0, 1'b0);
        v = 32'd6;        send(FMT_J, JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, v, ref_word(FMT_J, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, v), 1'b1);
        v = 32'd5;        send(FMT_J, JAL,    5'd1, 5'd0, 5'd0, 3'd0, 7'd0, v, 32'd0, 1'b0);
        v = 32'hABCDE001; send(FMT_U, LUI,    5'd7, 5'd0, 5'd0, 3'd0, 7'd0, v, 32'd0, 1'b0);
        v = 32'hFFFFF000; send(FMT_U, LUI,    5'd7, 5'd0, 5'd0, 3'd0, 7'd0, v, ref_word(FMT_U, LUI, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, v), 1'b1);
        v = 32'hDEADBEEF; send(FMT_R, OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, v, ref_word(FMT_R, OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, v), 1'b1);
        v = 32'd0;        send(3'd6,  OP,     5'd3, 5'd1, 5'd2, 3'd0, 7'd0, v, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [4:0] d, s;
            logic [2:0] f3;
            d  = 5'($urandom_range(0, 31));
            s  = 5'($urandom_range(0, 31));
            f3 = 3'($urandom_range(0, 7));
            v  = 32'($urandom_range(0, 4095)) - 32'd2048;
            send(FMT_I, OP_IMM, d, s, 5'd0, f3, 7'd0, v, ref_word(FMT_I, OP_IMM, d, s, 5'd0, f3, 7'd0, v), 1'b1);
        end
        wait_idle("boundaries");
    endtask

    task automatic test_back_to_back();
        time t0;
        out_ready = 1'b1;
        send(FMT_I, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1, ref_word(FMT_I, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1), 1'b1);
        t0 = accept_time;
        send(FMT_I, OP_IMM, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2, ref_word(FMT_I, OP_IMM, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2), 1'b1);
        checks++;
        if (accept_time - t0 != 30) begin
            errors++;
            $display("FAIL throughput: got %0t between accepts, required 30 (3 cycles)", accept_time - t0);
        end
        wait_idle("back_to_back");
    endtask

    task automatic test_backpressure();
        logic [31:0] wa, wb, aa;
        int n;
        wa = ref_word(FMT_I, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        wb = ref_word(FMT_I, OP_IMM, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
        out_ready = 1'b0;
        aa = exp_addr;
        send(FMT_I, OP_IMM, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, wa, 1'b1);
        n = 0;
        while (!out_valid && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        formato = FMT_I; opcode = OP_IMM; rd = 5'd4; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = 32'd9; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || instruction !== wa || address !== aa) begin
                errors++;
                $display("FAIL backpressure_hold: cycle %0d in_ready=%b out_valid=%b instruction=%h address=%h, required 0 1 %h %h",
                         c, in_ready, out_valid, instruction, address, wa, aa);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_accept: in_ready=%b, required 0", in_ready);
        end
        sb.push_back('{wb, exp_addr, 1'b0, exp_nerr});
        exp_addr += 32'd4;
        wait_idle("backpressure");
    endtask

    task automatic test_reset_midop();
        out_ready = 1'b1;
        send(FMT_B, BRANCH, 5'd0, 5'd1, 5'd1, 3'd0, 7'd0, 32'd1, 32'd0, 1'b0);
        reset_check("reset_codifica");
        out_ready = 1'b0;
        send(FMT_U, LUI, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001001, 32'd0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || erro !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_saida: out_valid=%b erro=%b, required 1 1", out_valid, erro);
        end
        reset_check("reset_saida");
        out_ready = 1'b1;
        send(FMT_U, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b1);
        wait_idle("after_reset");
    endtask

    task automatic test_saturation();
        reset_check("reset_before_saturation");
        out_ready = 1'b1;
        for (int i = 0; i < 258; i++) begin
            send(3'd7, OP, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'd0, 1'b0);
        end
        wait_idle("saturation");
        checks++;
        if (n_erros !== 8'd255) begin
            errors++;
            $display("FAIL saturation: n_erros=%0d, required 255", n_erros);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        formato = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0;
        funct3 = '0; funct7 = '0; imm = '0;
        exp_addr = BASE; exp_nerr = 8'd0; accept_time = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_addi_latency();
        test_store_branch();
        test_illegal();
        test_boundaries();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/montador_instrucao.md
Name: montador_instrucao

Overview:
- Encodes RV32I instruction fields plus a signed 32-bit immediate into a 32-bit instruction word; the inverse of the immediate generator.
- Used by the program loader and self-test path to assemble words and hand them, with the target word address, to instruction-memory write logic.
- Input and output use valid/ready handshakes.
- Immediate range and alignment are checked per format; an illegal request emits a NOP and flags an error.

Parameters:
- ADDR_W, 32, width of the emitted byte address.
- BASE_ADDR, 0, address of the first emitted word after reset.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- formato  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 reserved.
- opcode  input  7  opcode field, copied to bits 6:0.
- rd  input  5  destination register.
- rs1  input  5  source register 1.
- rs2  input  5  source register 2.
- funct3  input  3  funct3 field.
- funct7  input  7  funct7 field, R format only.
- imm  input  32  signed immediate, full value; for U, the value whose bits 31:12 are encoded.
- out_valid  output  1  encoded word present.
- out_ready  input  1  consumer accepts the word.
- instruction  output  32  encoded word.
- address  output  ADDR_W  byte address of the word.
- erro  output  1  the presented word replaces an illegal request.
- n_erros  output  8  saturating count of illegal requests.

Behaviour:
- Reset (asynchronous, any state, including mid-operation) sets:
  - state=OCIOSO, in_ready=1, out_valid=0.
  - instruction=0, erro=0, address=BASE_ADDR, n_erros=0.
  - Any pending request is discarded.
- FSM states: OCIOSO, CODIFICA, SAIDA.
  - OCIOSO: in_ready=1. When in_valid=1, latch all inputs and go to CODIFICA.
  - CODIFICA: in_ready=0. Compute the word and check legality, register the result, go to SAIDA.
  - SAIDA: out_valid=1. Hold instruction, address and erro stable until out_ready=1. On that handshake:
    - address += 4, wrapping modulo 2^ADDR_W.
    - Go to OCIOSO.
- Latency: out_valid rises 2 cycles after the input handshake edge.
- Throughput: 1 word per 3 cycles with out_ready held high.
- in_ready is 0 in CODIFICA and SAIDA, so the block never accepts input while holding output.
- Encoding rules (bit ranges MSB to LSB):
  - R: funct7, rs2, rs1, funct3, rd, opcode. imm is ignored.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Legality, with imm treated as two's complement:
  - I and S: -2048 <= imm <= 2047.
  - B: -4096 <= imm <= 4094 and imm[0]=0.
  - J: -1048576 <= imm <= 1048574 and imm[0]=0.
  - U: imm[11:0]=0.
  - R: always legal.
  - formato 6 or 7: illegal.
- Illegal request:
  - instruction=32'h00000013 (NOP), erro=1.
  - n_erros increments once, saturating at 255.
  - Address still advances on the output handshake, so program layout is preserved.
- erro is valid only while out_valid=1; it clears with the next handshake.
- A new in_valid asserted on the same edge as the output handshake is not accepted; it is accepted on the next cycle, in OCIOSO.
- No combinational path from in_* to out_* or from out_ready to in_ready.

Decomposition:
- Shared package: formato codes (FMT_R..FMT_J), the NOP constant 32'h00000013, and RV32I opcode constants (OP_IMM, STORE, BRANCH, LUI, JAL, OP). The same package also serves gerador_imediato and the decoder.
- One combinational sub-module, codificador_imediato: inputs are formato and the latched fields; outputs are the word and a legal flag.
- The parent holds the FSM, registers, address counter and error counter.

Test Plan:
- addi x1,x2,5 (formato=1, opcode=0010011, rd=1, rs1=2, funct3=0, imm=5) -> instruction=0x00510093, erro=0, address=0x0, out_valid exactly 2 cycles after acceptance.
- sw x2,0(x1) followed by beq x1,x2,16, out_ready=1 -> 0x0020A023 at address 0x0, then 0x00208863 at address 0x4.
- jal x1,-4 (formato=5, opcode=1101111) -> 0xFFDFF0EF; lui x5,0x12345000 -> 0x123452B7.
- Illegal requests:
  - beq with imm=3 -> 0x00000013, erro=1, n_erros=1.
  - addi with imm=2048 -> NOP, n_erros=2.
  - formato=7 -> NOP, n_erros=3.
  - Address advances by 4 for each.
- Backpressure: hold out_ready=0 for 5 cycles in SAIDA while in_valid=1 -> instruction and address stable, in_ready=0, no second request accepted; release -> the second request is accepted the next cycle.
- Reset asserted in CODIFICA and again in SAIDA -> all outputs are immediately at their reset values (out_valid=0, address=BASE_ADDR, n_erros=0); the next request is encoded at BASE_ADDR.
